// File: rtl/cmd_phy_pkg.sv
// Shared types and constants for the CMD-line physical block arbiter.
package cmd_phy_pkg;

   // Default command/response width (one SD command frame)
   localparam int CMD_WIDTH_DEF = 48;

   // Sequencer states, fixed 3-bit encoding
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_RESP = 3'd2,
      ACK       = 3'd3,
      DONE      = 3'd4
   } state_t;

   // Completion status codes returned to the requester
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_NO_RESP = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   // Requester index to one-hot grant vector
   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational winner selection plus the
// "last served" preference register, advanced once per completed transfer.
module rr_arbiter_2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_update,
   input  logic       i_served_idx,
   output logic       o_win_idx,
   output logic       o_valid
);

   // Index that wins when both requesters are active
   logic r_prefer_idx;

   // Preference flips to the requester that was not just served
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prefer_idx <= 1'b0;
      end else if (i_update) begin
         r_prefer_idx <= ~i_served_idx;
      end
   end

   // Winner: a lone requester always wins, contention uses the preference
   always_comb begin
      o_valid   = |i_req;
      o_win_idx = 1'b0;
      case (i_req)
         2'b01:   o_win_idx = 1'b0;
         2'b10:   o_win_idx = 1'b1;
         2'b11:   o_win_idx = r_prefer_idx;
         default: o_win_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cmd_phy_arbiter.sv
// Sequencer/arbiter sharing one CMD-line physical block between the host
// command controller (index 0) and the card-init sequencer (index 1).
// One command at a time: grant, strobe, wait for response or timeout,
// acknowledge the physical block, then report completion to the requester.
module cmd_phy_arbiter
   import cmd_phy_pkg::*;
#(
   parameter int CMD_WIDTH      = CMD_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 iClock_SD,
   input  logic                 iReset_n,
   input  logic [1:0]           iReq,
   input  logic [CMD_WIDTH-1:0] iCommand_0,
   input  logic [CMD_WIDTH-1:0] iCommand_1,
   output logic [1:0]           oGrant,
   output logic [1:0]           oDone,
   output logic [CMD_WIDTH-1:0] oResponse,
   output logic [1:0]           oStatus,
   output logic                 oStrobe_in,
   output logic [CMD_WIDTH-1:0] oCommand_from_CC,
   output logic                 oAck_in,
   output logic                 oCommand_timeout,
   input  logic                 iTransmission_complete,
   input  logic                 iReception_complete,
   input  logic                 iNo_response,
   input  logic [CMD_WIDTH-1:0] iPad_response,
   input  logic                 iAck_out
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_gnt_idx;
   logic [1:0]           r_grant;
   logic [1:0]           r_done;
   logic [CMD_WIDTH-1:0] r_resp;
   logic [1:0]           r_status;
   logic                 r_strobe;
   logic [CMD_WIDTH-1:0] r_cmd;
   logic                 r_ack;
   logic                 r_timeout;
   // Result captured on WAIT_RESP exit, published to the requester at DONE
   logic [CMD_WIDTH-1:0] r_cap_resp;
   logic [1:0]           r_cap_status;

   logic                 w_win_idx;
   logic                 w_any_req;
   logic                 w_rr_update;
   logic                 w_exit;
   logic                 w_timeout_hit;
   logic [1:0]           w_exit_status;
   logic [CMD_WIDTH-1:0] w_exit_resp;

   // The preference advances while in DONE, so the next IDLE sees it
   assign w_rr_update = (r_state == DONE);

   rr_arbiter_2 u_rr (
      .i_clk        (iClock_SD),
      .i_rst_n      (iReset_n),
      .i_req        (iReq),
      .i_update     (w_rr_update),
      .i_served_idx (r_gnt_idx),
      .o_win_idx    (w_win_idx),
      .o_valid      (w_any_req)
   );

   // WAIT_RESP exit decode: reception beats no-response beats timeout
   always_comb begin
      w_exit        = 1'b0;
      w_timeout_hit = 1'b0;
      w_exit_status = ST_OK;
      w_exit_resp   = '0;
      if (iReception_complete) begin
         w_exit      = 1'b1;
         w_exit_resp = iPad_response;
      end else if (iNo_response) begin
         w_exit        = 1'b1;
         w_exit_status = ST_NO_RESP;
      end else if (r_cnt == CNT_LAST) begin
         w_exit        = 1'b1;
         w_timeout_hit = 1'b1;
         w_exit_status = ST_TIMEOUT;
      end
   end

   // Sequencer FSM with all physical-block and requester outputs registered
   always_ff @(posedge iClock_SD) begin
      if (!iReset_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_gnt_idx    <= 1'b0;
         r_grant      <= 2'b00;
         r_done       <= 2'b00;
         r_resp       <= '0;
         r_status     <= ST_OK;
         r_strobe     <= 1'b0;
         r_cmd        <= '0;
         r_ack        <= 1'b0;
         r_timeout    <= 1'b0;
         r_cap_resp   <= '0;
         r_cap_status <= ST_OK;
      end else begin
         // Single-cycle pulses fall back to zero unless re-asserted below
         r_done    <= 2'b00;
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_gnt_idx <= w_win_idx;
                  r_grant   <= idx_to_onehot(w_win_idx);
                  r_cmd     <= w_win_idx ? iCommand_1 : iCommand_0;
                  r_strobe  <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               // No timeout here: the physical block always finishes shifting
               if (iTransmission_complete) begin
                  r_cnt   <= '0;
                  r_state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               if (w_exit) begin
                  r_cap_resp   <= w_exit_resp;
                  r_cap_status <= w_exit_status;
                  r_timeout    <= w_timeout_hit;
                  r_strobe     <= 1'b0;
                  r_ack        <= 1'b1;
                  r_state      <= ACK;
               end
            end
            ACK: begin
               if (iAck_out) begin
                  r_ack    <= 1'b0;
                  r_done   <= r_grant;
                  r_resp   <= r_cap_resp;
                  r_status <= r_cap_status;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_grant <= 2'b00;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign oGrant           = r_grant;
   assign oDone            = r_done;
   assign oResponse        = r_resp;
   assign oStatus          = r_status;
   assign oStrobe_in       = r_strobe;
   assign oCommand_from_CC = r_cmd;
   assign oAck_in          = r_ack;
   assign oCommand_timeout = r_timeout;

endmodule

// File: doc/cmd_phy_arbiter.md
# cmd_phy_arbiter

Sequencer and arbiter for the CMD-line physical block. Two requesters, the host command controller (index 0) and the card-init sequencer (index 1), share a single physical block through this unit. It grants one 48-bit command at a time round-robin and drives the physical block's strobe/ack handshake. It times out missing responses and returns the response or status to the granted requester.

## Interface
Parameters:
- CMD_WIDTH, 48, command/response width in bits.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_RESP before declaring timeout (≥2).

Ports:
- iClock_SD  in  1  SD clock; single clock domain, all logic on rising edge.
- iReset_n  in  1  reset, synchronous, active-low.
- iReq  in  2  per-requester request, level; held until matching oDone.
- iCommand_0  in  CMD_WIDTH  command from requester 0; sampled at grant.
- iCommand_1  in  CMD_WIDTH  command from requester 1; sampled at grant.
- oGrant  out  2  one-hot grant, high from ISSUE through DONE.
- oDone  out  2  one-cycle completion pulse to the granted requester.
- oResponse  out  CMD_WIDTH  latched response; valid with oDone, held until the next completion.
- oStatus  out  2  00 OK, 01 NO_RESPONSE, 10 TIMEOUT; valid with oDone, held until the next completion.
- oStrobe_in  out  1  to physical block: start transfer.
- oCommand_from_CC  out  CMD_WIDTH  to physical block: latched command, stable while granted.
- oAck_in  out  1  to physical block: completion acknowledge.
- oCommand_timeout  out  1  high for one cycle when the timeout fires.
- iTransmission_complete  in  1  from physical block: command shifted out.
- iReception_complete  in  1  from physical block: response captured.
- iNo_response  in  1  from physical block: no start bit seen.
- iPad_response  in  CMD_WIDTH  from physical block: response word, valid with iReception_complete.
- iAck_out  in  1  from physical block: acknowledge of oAck_in.

## Operation
- Reset (iReset_n=0 at a clock edge): every output is 0, state IDLE, timeout counter 0, round-robin pointer = requester 0 preferred. Reset mid-transfer aborts the transfer with no oDone.
- FSM states: IDLE, ISSUE, WAIT_RESP, ACK, DONE.
- IDLE: if any iReq is high, the arbiter selects the winner.
  - Only one requester active: it wins.
  - Both active: the one not served last wins.
  - On the next edge: latch the winner's command into oCommand_from_CC, set oGrant, go to ISSUE.
- ISSUE: oStrobe_in=1. When iTransmission_complete=1, go to WAIT_RESP and clear the counter. ISSUE has no timeout.
- WAIT_RESP: oStrobe_in stays 1 and the counter increments each cycle. Exits, in priority order:
  - iReception_complete: latch iPad_response, status OK.
  - iNo_response: status NO_RESPONSE; oResponse is zeroed.
  - counter == TIMEOUT_CYCLES-1: status TIMEOUT, pulse oCommand_timeout; oResponse is zeroed.
  - Each exit goes to ACK.
- ACK: oStrobe_in=0, oAck_in=1. When iAck_out=1, go to DONE.
- DONE: oAck_in=0. Pulse oDone for the granted index, update the round-robin pointer to prefer the other requester, clear oGrant on the next edge, return to IDLE.
- Dropping iReq while granted is ignored: the transfer completes and oDone still pulses.
- Requests are re-evaluated only in IDLE. Any requester still high in IDLE right after DONE is treated as a new request.

## Timing
- iReq rising in IDLE: oGrant and oStrobe_in are high on the next edge (latency 1).
- iTransmission_complete sampled in ISSUE: WAIT_RESP on the next edge.
- Timeout fires after exactly TIMEOUT_CYCLES clocks in WAIT_RESP with no completion.
- Reception on the same edge as the timeout: reception wins and oCommand_timeout stays 0.
- iReception_complete and iNo_response together: reception wins.
- iAck_out sampled high in ACK: DONE on the next edge. oDone lasts exactly one cycle.
- Minimum request-to-request spacing: DONE→IDLE→ISSUE, so two idle-visible cycles between strobes.
- Counter width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.

## Structure
- Package cmd_phy_pkg holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT_RESP=2, ACK=3, DONE=4, 3-bit encoding);
  - status constants ST_OK, ST_NO_RESP, ST_TIMEOUT;
  - the default CMD_WIDTH.
- Sub-module rr_arbiter_2 computes the 2-way round-robin winner combinationally and holds the last-served pointer register, updated by an input pulse from DONE.

## Test plan
- Single request: iReq=01, iCommand_0=48'h0000_0000_0FFF, transmission complete at cycle 10, reception with 48'h7 at cycle 30, iAck_out after 2 cycles → oCommand_from_CC=48'hFFF, oDone=01, oStatus=00, oResponse=48'h7.
- Contention: iReq=11 held across two transfers → grants 01 then 10. A third round with iReq=11 grants 01.
- Timeout: no reception/no_response for TIMEOUT_CYCLES=64 → oCommand_timeout pulses exactly 64 cycles after entering WAIT_RESP, then oStatus=10, oResponse=0, oDone pulses after iAck_out.
- No response: iNo_response at WAIT_RESP cycle 5 → oStatus=01, no timeout pulse. Reception and timeout on the same edge → oStatus=00.
- Reset mid-transfer: iReset_n=0 for one cycle during WAIT_RESP → all outputs 0 on the next edge, no oDone, and a fresh request afterwards completes normally.
